// File: rtl/ps_bigreg_assembler.sv
// Gathers NUM_SAMPLES consecutive mem-map writes into staging and commits them as one
// wide register over a valid/ready handshake when the VALID entry is written.
module ps_bigreg_assembler #(
  parameter int MEM_SIZE    = 256,
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_SAMPLES = 16,
  parameter int BASE_ID     = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_valid,
  input  logic [$clog2(MEM_SIZE)-1:0]       wr_id,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  output logic                              wr_resp_valid,
  output logic [1:0]                        wr_resp,
  output logic [NUM_SAMPLES-1:0]            fresh,
  output logic [NUM_SAMPLES*DATA_WIDTH-1:0] bigreg_data,
  output logic                              bigreg_valid,
  input  logic                              bigreg_ready
);

  localparam int BW = NUM_SAMPLES * DATA_WIDTH;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [BW-1:0]          staging_q, staging_d;
  logic [NUM_SAMPLES-1:0] fresh_q, fresh_d;
  logic [BW-1:0]          bigreg_data_q, bigreg_data_d;
  logic                   bigreg_valid_q, bigreg_valid_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [1:0]             resp_q, resp_d;

  logic [31:0] id_ext_s;
  logic [31:0] slot_idx_s;
  logic        in_window_s;
  logic        is_valid_entry_s;
  logic        is_slot_s;

  // Address decode: IDs are widened to 32 bits so BASE_ID+NUM_SAMPLES never wraps.
  assign id_ext_s         = 32'(wr_id);
  assign slot_idx_s       = id_ext_s - 32'(BASE_ID);
  assign in_window_s      = wr_valid && (id_ext_s >= 32'(BASE_ID))
                            && (id_ext_s <= 32'(BASE_ID + NUM_SAMPLES));
  assign is_valid_entry_s = wr_valid && (id_ext_s == 32'(BASE_ID + NUM_SAMPLES));
  assign is_slot_s        = in_window_s && !is_valid_entry_s;

  // Next-state logic: slot staging, commit on VALID entry, handshake release.
  always_comb begin
    state_d        = state_q;
    staging_d      = staging_q;
    fresh_d        = fresh_q;
    bigreg_data_d  = bigreg_data_q;
    bigreg_valid_d = bigreg_valid_q;
    resp_valid_d   = in_window_s;
    resp_d         = RESP_OKAY;

    // Slot writes stage in either state; at most one write per cycle, so never with a commit.
    for (int i = 0; i < NUM_SAMPLES; i++) begin
      if (is_slot_s && (slot_idx_s == 32'(i))) begin
        staging_d[i*DATA_WIDTH +: DATA_WIDTH] = wr_data;
        fresh_d[i]                            = 1'b1;
      end else begin
        fresh_d[i] = fresh_q[i];
      end
    end

    case (state_q)
      ST_COLLECT: begin
        if (is_valid_entry_s) begin
          if (&fresh_q) begin
            bigreg_data_d  = staging_q;
            bigreg_valid_d = 1'b1;
            fresh_d        = '0;
            state_d        = ST_HOLD;
          end else begin
            resp_d = RESP_SLVERR;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_HOLD: begin
        if (is_valid_entry_s) begin
          resp_d = RESP_SLVERR;
        end else begin
          resp_d = RESP_OKAY;
        end
        if (bigreg_valid_q && bigreg_ready) begin
          bigreg_valid_d = 1'b0;
          state_d        = ST_COLLECT;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        bigreg_valid_d = 1'b0;
        state_d        = ST_COLLECT;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_COLLECT;
      staging_q      <= '0;
      fresh_q        <= '0;
      bigreg_data_q  <= '0;
      bigreg_valid_q <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_q         <= 2'b00;
    end else begin
      state_q        <= state_d;
      staging_q      <= staging_d;
      fresh_q        <= fresh_d;
      bigreg_data_q  <= bigreg_data_d;
      bigreg_valid_q <= bigreg_valid_d;
      resp_valid_q   <= resp_valid_d;
      resp_q         <= resp_d;
    end
  end

  assign wr_resp_valid = resp_valid_q;
  assign wr_resp       = resp_q;
  assign fresh         = fresh_q;
  assign bigreg_data   = bigreg_data_q;
  assign bigreg_valid  = bigreg_valid_q;

endmodule

// File: doc/ps_bigreg_assembler.md
Name: ps_bigreg_assembler

Overview:
- Sits between the AXI-Lite memory-map write path and any RTL consumer of a PS_BIGREG: the seed bank, channel mux or sample-discriminator config.
- Collects NUM_SAMPLES consecutive 16-bit mem-map entries starting at BASE_ID.
- A write to the VALID entry (BASE_ID+NUM_SAMPLES) commits them as one wide register to the RTL over a valid/ready handshake.
- Tracks per-entry fresh bits, clears them on commit, and returns an OKAY/SLVERR code per accepted write.

Parameters:
- MEM_SIZE, 256, mem-map depth; ID width = $clog2(MEM_SIZE).
- DATA_WIDTH, 16, useful bits per mem-map entry (WD_DATA_WIDTH).
- NUM_SAMPLES, 16, number of entries in the big register (16 for seeds, 2 for chan mux, 16 for SDC).
- BASE_ID, 1, mem-map index of entry 0; the VALID entry sits at BASE_ID+NUM_SAMPLES.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  mem-map write strobe, at most one write per cycle
- wr_id  in  $clog2(MEM_SIZE)  mem-map index of the write
- wr_data  in  DATA_WIDTH  write payload (lower 16 bits of the AXI word)
- wr_resp_valid  out  1  response strobe for an in-window write
- wr_resp  out  2  00 OKAY, 10 SLVERR
- fresh  out  NUM_SAMPLES  per-entry fresh bits; bit i = entry BASE_ID+i written since last commit
- bigreg_data  out  NUM_SAMPLES*DATA_WIDTH  committed register; entry i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- bigreg_valid  out  1  committed data available
- bigreg_ready  in  1  consumer accepts bigreg_data

Behaviour:
- Reset (rst high at a clk edge):
  - all outputs become 0: staging, fresh, bigreg_data, bigreg_valid, wr_resp_valid, wr_resp.
  - FSM goes to COLLECT; any pending commit is discarded.
- Window:
  - in-window IDs are BASE_ID .. BASE_ID+NUM_SAMPLES.
  - writes outside the window are ignored: no state change, no response.
- Response timing: every in-window write produces exactly one wr_resp_valid pulse, one cycle after wr_valid, with wr_resp registered alongside it.
- Slot write (wr_id = BASE_ID+i, i < NUM_SAMPLES), accepted in any state:
  - staging[i] <= wr_data; fresh[i] <= 1; resp OKAY.
  - Rewriting a fresh slot overwrites it (last write wins), resp OKAY.
- FSM states: COLLECT, HOLD.
- COLLECT, VALID-entry write:
  - If fresh is all ones: bigreg_data <= staging; bigreg_valid <= 1; fresh <= 0; go to HOLD; resp OKAY. bigreg_valid is high the cycle after the write, the same cycle as wr_resp_valid.
  - Otherwise: resp SLVERR; staging, fresh and bigreg are unchanged; stay in COLLECT.
  - wr_data of a VALID-entry write is ignored.
- HOLD:
  - bigreg_data is held stable while bigreg_valid && !bigreg_ready.
  - A VALID-entry write in HOLD gets resp SLVERR, is dropped, and fresh is unchanged.
  - Slot writes still stage normally and do not disturb bigreg_data.
- Handshake:
  - The transfer completes on the cycle where bigreg_valid && bigreg_ready: next cycle bigreg_valid <= 0 and the FSM returns to COLLECT.
  - bigreg_ready while in COLLECT has no effect.
  - bigreg_valid never drops without a handshake, except on reset.
- Simultaneous commit and handshake: not possible, because a commit only happens in COLLECT and a handshake only in HOLD.
- Back-to-back commits: the earliest is the cycle after the handshake completes; a VALID write in the handshake cycle itself is still in HOLD and gets SLVERR.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
1. Full load (defaults): write 16'h1000+i to IDs 1..16, then a write to ID 17 with bigreg_ready=1.
   - Every response is OKAY.
   - bigreg_valid pulses for 1 cycle with entry i = 16'h1000+i.
   - fresh returns to 0.
2. Partial load: write IDs 1..15 only, then write ID 17.
   - Response is SLVERR, bigreg_valid stays 0, fresh = 16'h7FFF.
   - Writing ID 16 and then ID 17 gives OKAY and a commit.
3. Backpressure: commit with bigreg_ready=0 for 5 cycles.
   - bigreg_valid and bigreg_data are stable throughout.
   - Reload all slots and write ID 17 during the hold: SLVERR.
   - Raise ready: one-cycle handshake; a new VALID write afterwards commits the new data.
4. Overwrite and out-of-window: write ID 3 = 16'hAAAA then ID 3 = 16'h5555; write IDs 0 and 18.
   - Committed entry 2 = 16'h5555.
   - IDs 0 and 18 produce no wr_resp_valid and no state change.
5. Reset mid-operation: assert rst in HOLD with bigreg_valid=1 and fresh partially set.
   - Next cycle all outputs are 0 and the FSM is in COLLECT.
   - A following write to ID 17 returns SLVERR.
6. Small config (NUM_SAMPLES=2, BASE_ID=30): write 16'hBEEF to ID 30, 16'hCAFE to ID 31, then write ID 32.
   - bigreg_data = 32'hCAFE_BEEF.
